// File: rtl/pipeline_hazard_controller.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Sequences the 5-stage MIPS pipeline. This block does three things:
//   * detects load-use hazards and inserts one bubble per hazard,
//   * flushes IF/ID and ID/EX when a branch/jump resolves taken in EX,
//   * runs a run / single-step / halt FSM so the debug unit can step the
//     pipeline one clock at a time.
// It also exports a cycle counter and a load-use stall counter for debug.
// ALU-to-ALU hazards are handled by the neighbouring forwarding_unit.
//
// Ports:
//   CLK100MHZ         in   system clock, rising edge
//   reset             in   asynchronous, active-high
//   start             in   pulse: leave IDLE/HALTED (ignored elsewhere)
//   step_mode         in   sampled with start: 1 = single-step, 0 = free run
//   step_req          in   pulse: advance one cycle (only in STEP_WAIT)
//   mem_read_2_3      in   ID/EX instruction is a load
//   rt_2_3            in   load destination register in ID/EX
//   rs_1_2, rt_1_2    in   source registers of the instruction in IF/ID
//   branch_taken_2_3  in   branch/jump resolved taken in EX
//   halt_4_5          in   HALT instruction present in MEM/WB
//   pc_enable         out  PC write enable
//   if_id_enable      out  IF/ID write enable
//   if_id_flush       out  IF/ID synchronous clear
//   id_ex_bubble      out  zero the ID/EX control signals
//   pipe_enable       out  global enable for ID/EX, EX/MEM, MEM/WB
//   halted            out  FSM is in HALTED
//   state             out  FSM state encoding (debug)
//   cycle_count       out  cycles the pipeline advanced (wraps)
//   stall_count       out  load-use bubbles inserted (saturates)
//
// The pipeline control outputs are combinational from the state register
// and the hazard inputs so that a hazard is acted on in the same cycle it
// is seen. Because the state register is asynchronously reset, those
// outputs fall to their idle values as soon as reset rises.
// ----------------------------------------------------------------------------
module pipeline_hazard_controller #(
  parameter int NB     = 5,
  parameter int NB_CYC = 32,
  parameter int NB_STL = 16
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  input  logic              start,
  input  logic              step_mode,
  input  logic              step_req,
  input  logic              mem_read_2_3,
  input  logic [NB-1:0]     rt_2_3,
  input  logic [NB-1:0]     rs_1_2,
  input  logic [NB-1:0]     rt_1_2,
  input  logic              branch_taken_2_3,
  input  logic              halt_4_5,
  output logic              pc_enable,
  output logic              if_id_enable,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              pipe_enable,
  output logic              halted,
  output logic [2:0]        state,
  output logic [NB_CYC-1:0] cycle_count,
  output logic [NB_STL-1:0] stall_count
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_STEP_ONE  = 3'd3,
    ST_HALTED    = 3'd4
  } state_e;

  // A load in ID/EX whose destination is read by the instruction in IF/ID.
  // Register 0 is hard-wired to zero, so a "load" into it never conflicts.
  function automatic logic f_load_use(
    input logic          mem_read,
    input logic [NB-1:0] load_rd,
    input logic [NB-1:0] src_rs,
    input logic [NB-1:0] src_rt
  );
    logic rd_nonzero;
    logic src_match;
    rd_nonzero = (load_rd != {NB{1'b0}});
    src_match  = (load_rd == src_rs) || (load_rd == src_rt);
    return mem_read && rd_nonzero && src_match;
  endfunction

  localparam logic [NB_STL-1:0] STALL_MAX = {NB_STL{1'b1}};

  state_e            state_q, state_d;
  logic [NB_CYC-1:0] cycle_q, cycle_d;
  logic [NB_STL-1:0] stall_q, stall_d;

  logic advancing_s;
  logic load_use_s;
  logic stall_apply_s;
  logic start_accept_s;

  assign advancing_s = (state_q == ST_RUN) || (state_q == ST_STEP_ONE);
  assign load_use_s  = f_load_use(mem_read_2_3, rt_2_3, rs_1_2, rt_1_2);

  // Next-state logic for the run/step/halt sequencer.
  // The chosen mode is carried by the target state itself (RUN vs
  // STEP_WAIT), which is how step_mode gets latched on the start edge.
  always_comb begin
    state_d        = state_q;
    start_accept_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          start_accept_s = 1'b1;
          state_d        = step_mode ? ST_STEP_WAIT : ST_RUN;
        end else begin
          state_d = state_q;
        end
      end
      ST_RUN: begin
        if (halt_4_5) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STEP_WAIT: begin
        if (step_req) begin
          state_d = ST_STEP_ONE;
        end else begin
          state_d = ST_STEP_WAIT;
        end
      end
      ST_STEP_ONE: begin
        // Exactly one advancing cycle per step request.
        if (halt_4_5) begin
          state_d = ST_HALTED;
        end else begin
          state_d = ST_STEP_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pipeline control: branch flush beats load-use stall beats normal flow.
  // A taken branch squashes the instruction that would have stalled, so
  // the load-use condition is irrelevant in that cycle.
  always_comb begin
    pipe_enable   = 1'b0;
    pc_enable     = 1'b0;
    if_id_enable  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    stall_apply_s = 1'b0;
    if (advancing_s) begin
      pipe_enable = 1'b1;
      if (branch_taken_2_3) begin
        pc_enable    = 1'b1;
        if_id_enable = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (load_use_s) begin
        // Hold PC and IF/ID for one cycle; the load then moves on to
        // EX/MEM and the hazard clears by itself.
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b1;
        stall_apply_s = 1'b1;
      end else begin
        pc_enable    = 1'b1;
        if_id_enable = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
      end
    end else begin
      pipe_enable   = 1'b0;
      stall_apply_s = 1'b0;
    end
  end

  // Debug counters: both clear on an accepted start, which can only occur
  // while the pipeline is not advancing, so clear and count never collide.
  always_comb begin
    cycle_d = cycle_q;
    stall_d = stall_q;
    if (start_accept_s) begin
      cycle_d = {NB_CYC{1'b0}};
      stall_d = {NB_STL{1'b0}};
    end else begin
      if (advancing_s) begin
        cycle_d = cycle_q + NB_CYC'(1);
      end else begin
        cycle_d = cycle_q;
      end
      if (stall_apply_s && (stall_q != STALL_MAX)) begin
        stall_d = stall_q + NB_STL'(1);
      end else begin
        stall_d = stall_q;
      end
    end
  end

  // State and counter registers.
  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cycle_q <= {NB_CYC{1'b0}};
      stall_q <= {NB_STL{1'b0}};
    end else begin
      state_q <= state_d;
      cycle_q <= cycle_d;
      stall_q <= stall_d;
    end
  end

  assign state       = state_q;
  assign halted      = (state_q == ST_HALTED);
  assign cycle_count = cycle_q;
  assign stall_count = stall_q;

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences the 5-stage MIPS pipeline. Sits next to forwarding_unit in the top level; forwarding_unit handles ALU-to-ALU hazards.
- Detects load-use hazards and inserts one bubble per hazard. Flushes IF/ID and ID/EX on a taken branch.
- Runs a run/step/halt FSM for debug single-stepping.
- Exports a cycle counter and a load-use stall counter for the debug unit.

Parameters:
- NB, 5, register address width.
- NB_CYC, 32, cycle counter width.
- NB_STL, 16, stall counter width.

Ports:
- CLK100MHZ  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse; leave IDLE/HALTED.
- step_mode  in  1  sampled on start: 1 = single-step, 0 = free run.
- step_req  in  1  one-cycle pulse; advance pipeline one cycle in step mode.
- mem_read_2_3  in  1  ID/EX instruction is a load.
- rt_2_3  in  NB  load destination in ID/EX.
- rs_1_2  in  NB  IF/ID source register rs.
- rt_1_2  in  NB  IF/ID source register rt.
- branch_taken_2_3  in  1  branch/jump resolved taken in EX.
- halt_4_5  in  1  HALT instruction present in MEM/WB.
- pc_enable  out  1  PC register write enable.
- if_id_enable  out  1  IF/ID write enable.
- if_id_flush  out  1  IF/ID synchronous clear.
- id_ex_bubble  out  1  force ID/EX control signals to zero.
- pipe_enable  out  1  global enable for ID/EX, EX/MEM, MEM/WB.
- halted  out  1  FSM in HALTED.
- state  out  3  FSM state encoding, for debug.
- cycle_count  out  NB_CYC  cycles the pipeline advanced.
- stall_count  out  NB_STL  load-use bubbles inserted.

Behaviour:
- States: IDLE=0, RUN=1, STEP_WAIT=2, STEP_ONE=3, HALTED=4. Reset enters IDLE. All counters reset to 0.
- IDLE: on start, go to STEP_WAIT if step_mode=1, else RUN. step_mode is latched at that edge.
- RUN: on halt_4_5=1, go to HALTED at the next edge.
- STEP_WAIT: on step_req, go to STEP_ONE.
- STEP_ONE: unconditionally return to STEP_WAIT, or go to HALTED if halt_4_5=1 in that cycle.
- HALTED: on start, re-enter RUN or STEP_WAIT per step_mode. Both counters clear on that start.
- start in RUN, STEP_WAIT or STEP_ONE is ignored. step_req outside STEP_WAIT is ignored.
- "advancing" = state is RUN or STEP_ONE.
- When not advancing: pipe_enable=pc_enable=if_id_enable=0, and if_id_flush=id_ex_bubble=0.
- When advancing: pipe_enable=1.
- load_use (combinational) = mem_read_2_3 && rt_2_3!=0 && (rt_2_3==rs_1_2 || rt_2_3==rt_1_2).
- Priority when advancing:
  - 1) branch_taken_2_3: if_id_flush=1, id_ex_bubble=1, pc_enable=1, if_id_enable=1; load_use is ignored.
  - 2) load_use: pc_enable=0, if_id_enable=0, id_ex_bubble=1, if_id_flush=0.
  - 3) otherwise: pc_enable=if_id_enable=1, flush=bubble=0.
- All control outputs are combinational from state and inputs, with zero latency.
- A load-use stall lasts exactly one advancing cycle: next cycle the load has moved to EX/MEM, so load_use deasserts naturally. In step mode the stall consumes one step.
- cycle_count increments on every advancing cycle and wraps modulo 2^NB_CYC.
- stall_count increments on every advancing cycle where load_use is applied (case 2). It saturates at all-ones.
- halt_4_5 in the same cycle as a load_use or branch: that cycle's outputs still apply, then the FSM goes to HALTED.
- Asynchronous reset mid-run: all outputs drop to their IDLE values immediately, without waiting for a clock edge.
- Reset values: pc_enable=if_id_enable=if_id_flush=id_ex_bubble=pipe_enable=0, halted=0, state=0, cycle_count=0, stall_count=0.

Test Plan:
- Reset, start with step_mode=0, idle hazard inputs for 10 cycles: state=1, pc_enable=1, cycle_count=10, stall_count=0.
- RUN with mem_read_2_3=1, rt_2_3=5, rs_1_2=5 for one cycle: pc_enable=0, if_id_enable=0, id_ex_bubble=1, stall_count=1. Repeat with rt_2_3=0: no stall.
- RUN with load_use and branch_taken_2_3 both asserted: if_id_flush=1, id_ex_bubble=1, pc_enable=1, stall_count unchanged.
- start with step_mode=1, three step_req pulses 4 cycles apart: pipe_enable high exactly 3 single cycles, cycle_count=3, state returns to 2 after each pulse.
- halt_4_5=1 in RUN: next edge halted=1, pipe_enable=0, cycle_count frozen. New start clears both counters and resumes RUN.
- Assert reset mid-RUN between clock edges: outputs go to reset values before the next edge. start is ignored while reset=1.
